croma_button_sequencer: RTL and testbench

// - Front-end sequencer for the chroma/tone control datapath of the VGA display.
// - Turns the three raw board push-buttons into the datapath control signals:

---
 rtl/croma_button_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_croma_button_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/croma_button_sequencer.sv
// croma_button_sequencer: synchronises and debounces three push-buttons into UP/down step pulses and a TONO/LETRA/PANTALLA target select.
// Define AUTOREPEAT_EN to build the held-button auto-repeat timer; without it every press gives exactly one step.
module croma_button_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic       UP,
    output logic       down,
    output logic       TC,
    output logic       LP,
    output logic [1:0] mode
);

    localparam logic [1:0] S_TONO     = 2'b00;
    localparam logic [1:0] S_LETRA    = 2'b01;
    localparam logic [1:0] S_PANTALLA = 2'b10;

    localparam int B_UP   = 0;
    localparam int B_DN   = 1;
    localparam int B_MODE = 2;

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [1:0]  r_fill;
    logic [2:0]  r_deb;
    logic [2:0]  r_deb_d;
    logic [2:0]  r_arm;
    logic [15:0] r_cnt [3];
    logic        r_lock;
    logic        r_up;
    logic        r_dn;
    logic [1:0]  r_state;
    logic        r_tc;
    logic        r_lp;

    logic [2:0]  w_rise;
    logic        w_mode_adv;
    logic        w_step_up;
    logic        w_step_dn;
    logic        w_rep_up;
    logic        w_rep_dn;
    logic [1:0]  w_next_state;
    logic        w_tc;
    logic        w_lp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_fill  <= '0;
        end else begin
            r_sync1 <= {btn_mode, btn_down, btn_up};
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
        end
    end

    // A button is armed only once it has been seen released after reset, so a
    // press held through reset never produces a step or mode change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            r_arm   <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_deb_d <= r_deb;
            for (int i = 0; i < 3; i++) begin
                r_arm[i] <= r_arm[i] | (r_fill[1] & ~r_sync2[i] & ~r_deb[i]);
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign w_rise     = r_deb & ~r_deb_d & r_arm;
    assign w_mode_adv = w_rise[B_MODE];

    assign w_step_up = w_rise[B_UP] & ~r_deb[B_DN] & ~r_lock & ~w_mode_adv;
    assign w_step_dn = w_rise[B_DN] & ~r_deb[B_UP] & ~r_lock & ~w_mode_adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock <= 1'b0;
        end else if (w_mode_adv && (r_deb[B_UP] || r_deb[B_DN])) begin
            r_lock <= 1'b1;
        end else if (!r_deb[B_UP] && !r_deb[B_DN]) begin
            r_lock <= 1'b0;
        end
    end

`ifdef AUTOREPEAT_EN
    logic [23:0] r_rep_tmr;
    logic        r_rep_run;
    logic        r_rep_started;
    logic        w_rep_keep;
    logic        w_rep_fire;
    logic        w_first_step;

    assign w_first_step = w_step_up | w_step_dn;
    assign w_rep_keep   = r_rep_run & (r_deb[B_UP] ^ r_deb[B_DN]) & ~r_lock & ~w_mode_adv;
    assign w_rep_fire   = w_rep_keep &
                          (r_rep_started ? (r_rep_tmr == REPEAT_PERIOD - 24'd1)
                                         : (r_rep_tmr == REPEAT_DELAY - 24'd1));

    // The timer restarts on every issued pulse; it saturates rather than wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_tmr     <= '0;
            r_rep_run     <= 1'b0;
            r_rep_started <= 1'b0;
        end else if (w_first_step) begin
            r_rep_tmr     <= '0;
            r_rep_run     <= 1'b1;
            r_rep_started <= 1'b0;
        end else if (!w_rep_keep) begin
            r_rep_tmr     <= '0;
            r_rep_run     <= 1'b0;
            r_rep_started <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_tmr     <= '0;
            r_rep_started <= 1'b1;
        end else if (r_rep_tmr != 24'hFF_FFFF) begin
            r_rep_tmr <= r_rep_tmr + 24'd1;
        end
    end

    assign w_rep_up = w_rep_fire & r_deb[B_UP];
    assign w_rep_dn = w_rep_fire & r_deb[B_DN];
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign w_rep_up     = 1'b0;
    assign w_rep_dn     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_up <= 1'b0;
            r_dn <= 1'b0;
        end else begin
            r_up <= w_step_up | w_rep_up;
            r_dn <= w_step_dn | w_rep_dn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_TONO;
            r_tc    <= 1'b1;
            r_lp    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_tc    <= w_tc;
            r_lp    <= w_lp;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_TONO:     if (w_mode_adv) w_next_state = S_LETRA;
            S_LETRA:    if (w_mode_adv) w_next_state = S_PANTALLA;
            S_PANTALLA: if (w_mode_adv) w_next_state = S_TONO;
            default:    w_next_state = S_TONO;
        endcase
    end

    // Select lines are decoded from the next state so they move with mode.
    always_comb begin
        w_tc = 1'b0;
        w_lp = 1'b0;
        case (w_next_state)
            S_TONO:  w_tc = 1'b1;
            S_LETRA: w_lp = 1'b1;
            default: begin
                w_tc = 1'b0;
                w_lp = 1'b0;
            end
        endcase
    end

    assign UP   = r_up;
    assign down = r_dn;
    assign TC   = r_tc;
    assign LP   = r_lp;
    assign mode = r_state;

endmodule

// File: tb/tb_croma_button_sequencer.sv
// Directed bench for croma_button_sequencer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
module tb_croma_button_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic       UP;
    logic       down;
    logic       TC;
    logic       LP;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    croma_button_sequencer #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_PERIOD  (24'd5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .btn_mode(btn_mode),
        .UP      (UP),
        .down    (down),
        .TC      (TC),
        .LP      (LP),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected step pulse at cycle c for a press whose first pulse lands at
    // 'first' and whose raw release happens after cycle 'rel'.
    function automatic logic exp_pulse(input int c, input int first, input int rel);
`ifdef AUTOREPEAT_EN
        if (c == first) return 1'b1;
        return (c >= first + 20) && (c <= rel + 6) && (((c - first - 20) % 5) == 0);
`else
        return (c == first) && (c <= rel + 6);
`endif
    endfunction

    task automatic test_reset();
        for (int c = 1; c <= 3; c++) begin
            tick();
            if ({UP, down, TC, LP, mode} !== 6'b001000) begin
                $display("FAIL reset_hold c=%0d got=%b exp=001000", c, {UP, down, TC, LP, mode});
                errors++;
            end
            checks++;
        end
        reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if ({UP, down, TC, LP, mode} !== 6'b001000) begin
                $display("FAIL reset_idle c=%0d got=%b exp=001000", c, {UP, down, TC, LP, mode});
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_clean_up();
        btn_up = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if ({UP, down} !== {exp_pulse(c, 7, 30), 1'b0}) begin
                $display("FAIL clean_up c=%0d UP/down got=%b%b exp=%b0", c, UP, down, exp_pulse(c, 7, 30));
                errors++;
            end
            if ({TC, LP, mode} !== 4'b1000) begin
                $display("FAIL clean_up_mode c=%0d got=%b exp=1000", c, {TC, LP, mode});
                errors++;
            end
            checks += 2;
            if (c == 30) btn_up = 1'b0;
        end
    endtask

    task automatic test_bounce();
        btn_up = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if ({UP, down} !== {exp_pulse(c, 19, 30), 1'b0}) begin
                $display("FAIL bounce c=%0d UP/down got=%b%b exp=%b0", c, UP, down, exp_pulse(c, 19, 30));
                errors++;
            end
            checks++;
            if (c <= 12 && (c % 2) == 0) btn_up = ~btn_up;
            if (c == 30) btn_up = 1'b0;
        end
    endtask

    task automatic test_down();
        btn_down = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if ({UP, down} !== {1'b0, exp_pulse(c, 7, 30)}) begin
                $display("FAIL down_press c=%0d UP/down got=%b%b exp=0%b", c, UP, down, exp_pulse(c, 7, 30));
                errors++;
            end
            checks++;
            if (c == 30) btn_down = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        btn_up   = 1'b1;
        btn_down = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            tick();
            if ({UP, down} !== 2'b00) begin
                $display("FAIL simultaneous c=%0d UP/down got=%b%b exp=00", c, UP, down);
                errors++;
            end
            checks++;
            if (c == 20) begin
                btn_up   = 1'b0;
                btn_down = 1'b0;
            end
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] seq [4];
        logic [1:0] em;
        seq[0] = 2'b00;
        seq[1] = 2'b01;
        seq[2] = 2'b10;
        seq[3] = 2'b00;
        for (int p = 0; p < 3; p++) begin
            btn_mode = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                tick();
                em = (c >= 7) ? seq[p+1] : seq[p];
                if ({mode, TC, LP} !== {em, em == 2'b00, em == 2'b01}) begin
                    $display("FAIL mode_cycle p=%0d c=%0d mode/TC/LP got=%b exp=%b", p, c,
                             {mode, TC, LP}, {em, em == 2'b00, em == 2'b01});
                    errors++;
                end
                if ({UP, down} !== 2'b00) begin
                    $display("FAIL mode_cycle_steps p=%0d c=%0d got=%b%b exp=00", p, c, UP, down);
                    errors++;
                end
                checks += 2;
                if (c == 10) btn_mode = 1'b0;
            end
        end
    endtask

    task automatic test_lockout();
        logic [1:0] em;
        btn_down = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            tick();
            em = (c >= 17) ? 2'b01 : 2'b00;
            if ({UP, down} !== {c == 62, c == 7}) begin
                $display("FAIL lockout c=%0d UP/down got=%b%b exp=%b%b", c, UP, down, c == 62, c == 7);
                errors++;
            end
            if ({mode, TC, LP} !== {em, em == 2'b00, em == 2'b01}) begin
                $display("FAIL lockout_mode c=%0d got=%b exp=%b", c, {mode, TC, LP}, {em, em == 2'b00, em == 2'b01});
                errors++;
            end
            checks += 2;
            case (c)
                10: btn_mode = 1'b1;
                20: btn_mode = 1'b0;
                22: btn_up   = 1'b1;
                30: btn_down = 1'b0;
                40: btn_up   = 1'b0;
                55: btn_up   = 1'b1;
                68: btn_up   = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_mode_step_same_cycle();
        logic [1:0] em;
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            em = (c >= 7) ? 2'b10 : 2'b01;
            if ({UP, down} !== {c == 32, 1'b0}) begin
                $display("FAIL same_cycle c=%0d UP/down got=%b%b exp=%b0", c, UP, down, c == 32);
                errors++;
            end
            if ({mode, TC, LP} !== {em, em == 2'b00, em == 2'b01}) begin
                $display("FAIL same_cycle_mode c=%0d got=%b exp=%b", c, {mode, TC, LP}, {em, em == 2'b00, em == 2'b01});
                errors++;
            end
            checks += 2;
            if (c == 12) begin
                btn_mode = 1'b0;
                btn_up   = 1'b0;
            end
            if (c == 25) btn_up = 1'b1;
            if (c == 36) btn_up = 1'b0;
        end
    endtask

    task automatic test_reset_mid_hold();
        btn_up = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if ({UP, down, TC, LP, mode} !== {c == 7, 5'b00010}) begin
                $display("FAIL pre_reset c=%0d got=%b exp=%b", c, {UP, down, TC, LP, mode}, {c == 7, 5'b00010});
                errors++;
            end
            checks++;
        end
        reset = 1'b1;
        #1;
        if ({UP, down, TC, LP, mode} !== 6'b001000) begin
            $display("FAIL async_reset got=%b exp=001000", {UP, down, TC, LP, mode});
            errors++;
        end
        checks++;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            tick();
            if ({UP, down, TC, LP, mode} !== {c == 52, 5'b01000}) begin
                $display("FAIL post_reset c=%0d got=%b exp=%b", c, {UP, down, TC, LP, mode}, {c == 52, 5'b01000});
                errors++;
            end
            checks++;
            if (c == 30) btn_up = 1'b0;
            if (c == 45) btn_up = 1'b1;
            if (c == 55) btn_up = 1'b0;
        end
    endtask

`ifdef AUTOREPEAT_EN
    task automatic test_autorepeat();
        btn_down = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            tick();
            if ({UP, down} !== {1'b0, exp_pulse(c, 7, 60)}) begin
                $display("FAIL autorepeat c=%0d UP/down got=%b%b exp=0%b", c, UP, down, exp_pulse(c, 7, 60));
                errors++;
            end
            checks++;
            if (c == 60) btn_down = 1'b0;
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;
        test_reset();
        test_clean_up();
        test_bounce();
        test_down();
        test_simultaneous();
        test_mode_cycle();
        test_lockout();
        test_mode_step_same_cycle();
        test_reset_mid_hold();
`ifdef AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
